// File: rtl/hrfp_round.sv
// Base-16 floating-point rounding stage: two-stage valid/ready pipeline that applies
// the selected rounding mode to a normalized mantissa and handles carry, overflow, zero and specials.
module hrfp_round #(
    parameter int MODE_W = 2,
    parameter int EXPW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3+EXPW-1:0]  in_result,
    input  logic [30:0]        in_mantissa,
    input  logic [MODE_W-1:0]  rmode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [28+EXPW-1:0] out_result,
    output logic               out_inexact,
    output logic               out_overflow
);

    localparam logic [EXPW-1:0] EXP_MAX  = {EXPW{1'b1}};
    localparam logic [24:0]     MANT_ONE = 25'h0200000;

    function automatic logic calc_inc(input logic [MODE_W-1:0] mode, input logic sign,
                                      input logic l, input logic r, input logic s);
        logic inc_v;
        case (mode)
            MODE_W'(0): inc_v = r & (s | l);
            MODE_W'(1): inc_v = 1'b0;
            MODE_W'(2): inc_v = ~sign & (r | s);
            MODE_W'(3): inc_v = sign & (r | s);
            default:    inc_v = 1'b0;
        endcase
        return inc_v;
    endfunction

    logic            s1_valid_r, s1_special_r, s1_nan_r, s1_sign_r;
    logic [EXPW-1:0] s1_exp_r;
    logic [24:0]     s1_kept_r;
    logic            s1_zero_r, s1_inc_r, s1_inexact_r;

    logic            s1_load_s, s2_load_s;
    logic            in_special_s, in_sign_s, in_inc_s, in_rs_s;
    logic            unused_msb_s;

    logic            nx_special_s, nx_nan_s, nx_overflow_s, nx_inexact_s;
    logic [EXPW-1:0] nx_exp_s;
    logic [24:0]     nx_mant_s;
    logic [25:0]     sum_s;

    assign s2_load_s    = ~out_valid | out_ready;
    assign s1_load_s    = ~s1_valid_r | s2_load_s;
    assign in_ready     = s1_load_s;
    assign in_special_s = in_result[EXPW+2];
    assign in_sign_s    = in_result[EXPW];
    assign in_rs_s      = in_mantissa[4] | (|in_mantissa[3:0]);
    assign unused_msb_s = in_mantissa[30];

    // Rounding decision for the incoming operand; specials never increment.
    always_comb begin
        in_inc_s = 1'b0;
        if (in_special_s) begin
            in_inc_s = 1'b0;
        end else begin
            in_inc_s = calc_inc(rmode, in_sign_s, in_mantissa[5], in_mantissa[4], |in_mantissa[3:0]);
        end
    end

    // Stage 1 register: captures operand fields plus the decided increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_special_r <= 1'b0;
            s1_nan_r     <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= {EXPW{1'b0}};
            s1_kept_r    <= 25'd0;
            s1_zero_r    <= 1'b0;
            s1_inc_r     <= 1'b0;
            s1_inexact_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_special_r <= in_special_s;
                s1_nan_r     <= in_result[EXPW+1];
                s1_sign_r    <= in_sign_s;
                s1_exp_r     <= in_result[EXPW-1:0];
                s1_kept_r    <= in_mantissa[29:5];
                s1_zero_r    <= (in_mantissa[29:0] == 30'd0);
                s1_inc_r     <= in_inc_s;
                s1_inexact_r <= in_rs_s & ~in_special_s;
            end
        end
    end

    assign sum_s = {1'b0, s1_kept_r} + {25'd0, s1_inc_r};

    // Stage 2 datapath: priority is special passthrough, then zero, then digit carry.
    always_comb begin
        nx_special_s  = s1_special_r;
        nx_nan_s      = s1_nan_r;
        nx_exp_s      = s1_exp_r;
        nx_mant_s     = sum_s[24:0];
        nx_overflow_s = 1'b0;
        nx_inexact_s  = s1_inexact_r;
        if (s1_special_r) begin
            nx_mant_s    = s1_kept_r;
            nx_inexact_s = 1'b0;
        end else if (s1_zero_r) begin
            nx_exp_s     = {EXPW{1'b0}};
            nx_mant_s    = 25'd0;
            nx_inexact_s = 1'b0;
        end else if (sum_s[25]) begin
            if (s1_exp_r == EXP_MAX) begin
                nx_special_s  = 1'b1;
                nx_nan_s      = 1'b0;
                nx_exp_s      = EXP_MAX;
                nx_mant_s     = 25'd0;
                nx_overflow_s = 1'b1;
            end else begin
                nx_exp_s  = s1_exp_r + EXPW'(1);
                nx_mant_s = MANT_ONE;
            end
        end else begin
            nx_mant_s = sum_s[24:0];
        end
    end

    // Stage 2 / output register: holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= {(28+EXPW){1'b0}};
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_result   <= {nx_special_s, nx_nan_s, s1_sign_r, nx_exp_s, nx_mant_s};
                out_inexact  <= nx_inexact_s;
                out_overflow <= nx_overflow_s;
            end
        end
    end

endmodule

// File: tb/tb_hrfp_round.sv
// Directed-vector bench for hrfp_round: table of rounding cases plus
// backpressure and mid-stream reset sequences.
module tb_hrfp_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_result;
    logic [30:0] in_mantissa;
    logic [1:0]  rmode;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_result;
    logic        out_inexact;
    logic        out_overflow;

    int checks = 0;
    int errors = 0;

    hrfp_round #(.MODE_W(2), .EXPW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_mantissa(in_mantissa), .rmode(rmode),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_inexact(out_inexact), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sp, nan, sg;
        logic [7:0]  ex;
        logic [24:0] kept;
        logic        r;
        logic [3:0]  st;
        logic [1:0]  md;
        logic [35:0] er;
        logic        ei, eo;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic sp, logic nan, logic sg, logic [7:0] ex, logic [24:0] kept,
                                logic r, logic [3:0] st, logic [1:0] md,
                                logic esp, logic enan, logic [7:0] eex, logic [24:0] em,
                                logic ei, logic eo);
        vec_t v;
        v.sp = sp; v.nan = nan; v.sg = sg; v.ex = ex; v.kept = kept;
        v.r = r; v.st = st; v.md = md;
        v.er = {esp, enan, sg, eex, em};
        v.ei = ei; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic sp, input logic nan, input logic sg, input logic [7:0] ex,
                         input logic [24:0] kept, input logic r, input logic [3:0] st,
                         input logic [1:0] md);
        in_result   = {sp, nan, sg, ex};
        in_mantissa = {1'b0, kept, r, st};
        rmode       = md;
    endtask

    int          sent, rcvd, cyc;
    logic        saw_block, stalled, stale;
    logic [35:0] snap;
    logic [24:0] bp_kept[5];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 25'd0, 1'b0, 4'h0, 2'd0);

        vecs[0]  = mk(0,0,0,8'h40,25'h0400000,1,4'h0,2'd0, 0,0,8'h40,25'h0400000,1,0);
        vecs[1]  = mk(0,0,0,8'h40,25'h0400001,1,4'h0,2'd0, 0,0,8'h40,25'h0400002,1,0);
        vecs[2]  = mk(0,0,0,8'h41,25'h1FFFFFF,1,4'h0,2'd0, 0,0,8'h42,25'h0200000,1,0);
        vecs[3]  = mk(0,0,0,8'hFF,25'h1FFFFFF,1,4'h0,2'd0, 1,0,8'hFF,25'h0000000,1,1);
        vecs[4]  = mk(0,0,1,8'h40,25'h0800001,0,4'h1,2'd3, 0,0,8'h40,25'h0800002,1,0);
        vecs[5]  = mk(0,0,1,8'h40,25'h0800001,0,4'h1,2'd2, 0,0,8'h40,25'h0800001,1,0);
        vecs[6]  = mk(0,0,1,8'h40,25'h0800001,0,4'h1,2'd1, 0,0,8'h40,25'h0800001,1,0);
        vecs[7]  = mk(0,0,1,8'h33,25'h0000000,0,4'h0,2'd0, 0,0,8'h00,25'h0000000,0,0);
        vecs[8]  = mk(1,1,0,8'hFF,25'h0ABCDEF,1,4'h3,2'd2, 1,1,8'hFF,25'h0ABCDEF,0,0);
        vecs[9]  = mk(0,0,0,8'h12,25'h0123456,0,4'h0,2'd0, 0,0,8'h12,25'h0123456,0,0);
        vecs[10] = mk(0,0,0,8'h12,25'h0123456,1,4'h0,2'd2, 0,0,8'h12,25'h0123457,1,0);
        vecs[11] = mk(0,0,0,8'h12,25'h0123457,0,4'h8,2'd0, 0,0,8'h12,25'h0123457,1,0);

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven rounding cases, one at a time with latency check
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].sp, vecs[i].nan, vecs[i].sg, vecs[i].ex, vecs[i].kept,
                  vecs[i].r, vecs[i].st, vecs[i].md);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            rmode = ~vecs[i].md;
            chk($sformatf("v%0d_lat1", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_result", i), 64'(out_result), 64'(vecs[i].er));
            chk($sformatf("v%0d_inexact", i), 64'(out_inexact), 64'(vecs[i].ei));
            chk($sformatf("v%0d_overflow", i), 64'(out_overflow), 64'(vecs[i].eo));
        end

        // Backpressure: five operands, consumer stalls three cycles mid-stream
        for (int i = 0; i < 5; i++) bp_kept[i] = 25'h0100010 + 25'(i * 3);
        sent = 0; rcvd = 0; saw_block = 1'b0; stalled = 1'b0; snap = 36'd0;
        for (cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 5);
            if (sent < 5) drive(1'b0, 1'b0, 1'b0, 8'h21, bp_kept[sent], 1'b0, 4'h0, 2'd0);
            #1;
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && stalled)
                chk("bp_stable", 64'(out_result), 64'(snap));
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", rcvd), 64'(out_result),
                    64'({3'b000, 8'h21, bp_kept[rcvd]}));
                rcvd++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                snap = out_result;
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_in_ready_fell", 64'(saw_block), 64'd1);
        chk("bp_count", 64'(rcvd), 64'd5);
        #1;
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        // Reset with two operands in flight
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h30, 25'h0333333, 1'b0, 4'h0, 2'd0);
        in_valid = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h31, 25'h0444444, 1'b0, 4'h0, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs_inflight", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_out_valid_now", 64'(out_valid), 64'd0);
        chk("rs_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("rs_no_stale", 64'(stale), 64'd0);

        // First operand after reset is accepted on the first edge
        @(negedge clk);
        drive(vecs[2].sp, vecs[2].nan, vecs[2].sg, vecs[2].ex, vecs[2].kept,
              vecs[2].r, vecs[2].st, vecs[2].md);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_result", 64'(out_result), 64'(vecs[2].er));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hrfp_round.md
HRFP_ROUND -- requirements
Module: hrfp_round

Interface
REQ-001 SHALL have parameter MODE_W, default 2, meaning the width of the rounding-mode input.
REQ-002 SHALL have parameter EXPW, default 8, meaning the exponent field width (biased base-16 exponent).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset; it is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: normalized operand present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts the operand this cycle.
REQ-007 SHALL have port in_result, input, 3+EXPW bits: {special, is_nan, sign, exponent} from the normalize stage.
REQ-008 SHALL have port in_mantissa, input, 31 bits: normalized mantissa; [30] is always 0, [29:5] are the kept digits, [4] is the round bit and [3:0] are the sticky bits.
REQ-009 SHALL have port rmode, input, MODE_W bits: 0=RNE, 1=RTZ, 2=toward +inf, 3=toward -inf; sampled with the operand.
REQ-010 SHALL have port out_valid, output, 1 bit: rounded result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_result, output, 28+EXPW bits: {special, is_nan, sign, exponent, mantissa[24:0]}.
REQ-013 SHALL have port out_inexact, output, 1 bit: round or sticky bit was nonzero.
REQ-014 SHALL have port out_overflow, output, 1 bit: exponent saturated to infinity.

Function
REQ-015 SHALL be a two-stage pipeline, S1 then S2, each with its own valid bit; latency is exactly 2 cycles from an accepted input to out_valid when no stall occurs.
REQ-016 S2 SHALL load when !s2_valid || out_ready; S1 SHALL load when !s1_valid || S2 loads; in_ready SHALL equal the S1 load condition, giving full throughput (one operand per cycle) under continuous out_ready.
REQ-017 Transfers SHALL occur only on valid&&ready; a stalled stage SHALL hold its data and valid unchanged.
REQ-018 S1 SHALL compute from the input: L=mantissa[5], R=mantissa[4], S=|mantissa[3:0], zero=(mantissa[29:0]==0), and the increment flag inc.
REQ-019 The increment flag inc SHALL be computed per mode: RNE gives R&(S|L); RTZ gives 0; mode 2 gives !sign&(R|S); mode 3 gives sign&(R|S).
REQ-020 S2 SHALL compute sum = {1'b0, mantissa[29:5]} + inc, 26 bits wide.
REQ-021 When sum[25]=0, S2 SHALL output mantissa = sum[24:0] and leave the exponent unchanged.
REQ-022 When sum[25]=1 (carry out of the top hex digit), S2 SHALL output mantissa = 25'h0200000 (leading hex digit 1) and exponent+1.
REQ-023 When the carry case occurs with exponent==all-ones, S2 SHALL output special=1, is_nan=0, exponent all-ones, mantissa 0, and assert out_overflow=1.
REQ-024 When zero=1 and special=0, S2 SHALL output exponent 0 and mantissa 0, keep the sign, and clear both flags.
REQ-025 When special=1, S2 SHALL pass special, is_nan, sign, exponent and mantissa[29:5] through unchanged, with inc forced to 0 and both flags 0.
REQ-026 out_inexact SHALL equal (R|S) && !special, registered alongside out_result.
REQ-027 out_result and the flags SHALL be stable while out_valid && !out_ready.
REQ-028 The rmode value SHALL travel with its operand; a change of rmode SHALL NOT affect operands already in S1 or S2.

Reset
REQ-029 While rst_n=0, the block SHALL immediately clear s1_valid, s2_valid, out_valid, out_result, out_inexact and out_overflow to 0, and in_ready SHALL read 1.
REQ-030 Asserting reset mid-operation SHALL discard in-flight operands, with no partial output after release.
REQ-031 The first accept after rst_n rises SHALL be on the first clk edge with in_valid=1.

Verification
REQ-032 A bench SHALL cover RNE tie-to-even: mantissa {kept=25'h0400000, R=1, S=0}, exp 8'h40 -> mantissa 25'h0400000, exp 8'h40, inexact=1 (L=0, no increment).
REQ-033 A bench SHALL cover the RNE carry: kept=25'h1FFFFFF, R=1, exp 8'h41 -> mantissa 25'h0200000, exp 8'h42, inexact=1, overflow=0.
REQ-034 A bench SHALL cover exponent saturation: kept=25'h1FFFFFF, R=1, exp 8'hFF, RNE -> special=1, is_nan=0, mantissa 0, overflow=1.
REQ-035 A bench SHALL cover the directed modes: sign=1, R=0, S=1, kept=25'h0800001 -> mode 3 gives 25'h0800002; mode 2 and RTZ give 25'h0800001.
REQ-036 A bench SHALL cover backpressure: stream 5 operands with out_ready low for 3 cycles mid-stream -> in_ready falls once S1 and S2 are full, there is no loss or duplication, order is preserved, and outputs stay stable while stalled.
REQ-037 A bench SHALL cover reset mid-stream: drop rst_n with two operands in flight -> out_valid=0 at once, and no stale result appears after release.
